// File: rtl/nicem_tablo_denetleyici.sv
// Dequantization table controller: parses DQT bytes into de-zigzagged tables, tracks MCU components, serves lookups.
// Optional NICEM_16BIT_EN: accepts Pq=1 (two-byte big-endian values) and widens storage to 16 bits.
module nicem_tablo_denetleyici #(
  parameter int TABLO_SAYISI = 2,
`ifdef NICEM_16BIT_EN
  parameter int DQ_TABLO_BIT = 16,
`else
  parameter int DQ_TABLO_BIT = 8,
`endif
  parameter int BLOK_ALAN    = 64
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [7:0]              dqt_veri_i,
  input  logic                    dqt_gecerli_i,
  input  logic                    dqt_son_i,
  output logic                    dqt_hazir_o,
  input  logic [1:0]              cfg_mcu_yapi_i,
  input  logic                    cfg_y_tablo_i,
  input  logic                    cfg_c_tablo_i,
  input  logic                    mcu_sifirla_i,
  input  logic [5:0]              dq_index_i,
  input  logic                    dq_istek_i,
  input  logic                    blok_son_i,
  output logic [DQ_TABLO_BIT-1:0] dq_katsayi_o,
  output logic                    dq_gecerli_o,
  output logic [1:0]              bilesen_o,
  output logic                    hata_o,
  output logic [1:0]              durum_o
);
  // Byte handshake: a byte moves on any edge where dqt_gecerli_i && dqt_hazir_o.
  localparam int TW = (TABLO_SAYISI > 1) ? $clog2(TABLO_SAYISI) : 1;
  localparam int ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic [1:0] {BASLIK = 2'd0, DEGER = 2'd1, ATLA = 2'd2} durum_t;

  durum_t                  durum_q, durum_d;
  logic [5:0]              k_q, k_d;
  logic [TW-1:0]           tq_q, tq_d;
  logic [TABLO_SAYISI-1:0] gecerli_q, gecerli_d;
  logic                    hata_q, hata_d;
  logic [2:0]              s_q, s_d;
  logic                    aktif_q, aktif_d;
  logic [DQ_TABLO_BIT-1:0] tablo_q [TABLO_SAYISI][BLOK_ALAN];
  logic [DQ_TABLO_BIT-1:0] tablo_d [TABLO_SAYISI][BLOK_ALAN];
`ifdef NICEM_16BIT_EN
  logic                    pq_q, pq_d;
  logic                    faz_q, faz_d;
  logic [7:0]              ust_q, ust_d;
`endif

  logic                    kabul, baslik_iyi, tamam;
  logic [DQ_TABLO_BIT-1:0] deger;
  logic [TW-1:0]           sel;
  logic [2:0]              s_son;

  // Component sequence and table select
  always_comb begin
    case (cfg_mcu_yapi_i)
      2'd1:    s_son = 3'd2;
      2'd2:    s_son = 3'd5;
      default: s_son = 3'd0;
    endcase
    case (cfg_mcu_yapi_i)
      2'd1:    bilesen_o = s_q[1:0];
      2'd2:    bilesen_o = (s_q < 3'd4) ? 2'd0 : ((s_q == 3'd4) ? 2'd1 : 2'd2);
      default: bilesen_o = 2'd0;
    endcase
    sel          = TW'((bilesen_o == 2'd0) ? cfg_y_tablo_i : cfg_c_tablo_i);
    dq_katsayi_o = tablo_q[sel][dq_index_i];
    dq_gecerli_o = gecerli_q[sel];
    hata_o       = hata_q;
    durum_o      = durum_q;
  end

  // A header for the table the dequantizer is reading is stalled until its block ends.
  always_comb begin
    dqt_hazir_o = 1'b1;
    if (durum_q == BASLIK && aktif_q && dqt_gecerli_i && dqt_veri_i[3:0] == 4'(sel))
      dqt_hazir_o = 1'b0;
    kabul = dqt_gecerli_i && dqt_hazir_o;
  end

  always_comb begin
    s_d     = s_q;
    aktif_d = aktif_q;
    if (mcu_sifirla_i) begin
      s_d     = 3'd0;
      aktif_d = 1'b0;
    end else begin
      if (dq_istek_i) aktif_d = 1'b1;
      if (blok_son_i) begin
        aktif_d = 1'b0;
        s_d     = (s_q >= s_son) ? 3'd0 : s_q + 3'd1;
      end
    end
  end

  always_comb begin
    durum_d   = durum_q;
    k_d       = k_q;
    tq_d      = tq_q;
    gecerli_d = gecerli_q;
    hata_d    = hata_q;
    tablo_d   = tablo_q;
    tamam     = 1'b0;
    deger     = DQ_TABLO_BIT'(dqt_veri_i);
`ifdef NICEM_16BIT_EN
    pq_d       = pq_q;
    faz_d      = faz_q;
    ust_d      = ust_q;
    baslik_iyi = (dqt_veri_i[7:4] <= 4'd1) && (32'(dqt_veri_i[3:0]) < TABLO_SAYISI);
`else
    baslik_iyi = (dqt_veri_i[7:4] == 4'd0) && (32'(dqt_veri_i[3:0]) < TABLO_SAYISI);
`endif
    case (durum_q)
      BASLIK: if (kabul) begin
        if (baslik_iyi) begin
          tq_d                           = dqt_veri_i[TW-1:0];
          gecerli_d[dqt_veri_i[TW-1:0]]  = 1'b0;
          k_d                            = 6'd0;
          durum_d                        = DEGER;
`ifdef NICEM_16BIT_EN
          pq_d  = dqt_veri_i[4];
          faz_d = 1'b0;
`endif
        end else begin
          hata_d = 1'b1;
          if (!dqt_son_i) durum_d = ATLA;
        end
      end
      DEGER: if (kabul) begin
`ifdef NICEM_16BIT_EN
        if (pq_q && !faz_q) begin
          ust_d = dqt_veri_i;
          faz_d = 1'b1;
        end else begin
          faz_d = 1'b0;
          tamam = 1'b1;
          if (pq_q) deger = DQ_TABLO_BIT'({ust_q, dqt_veri_i});
        end
`else
        tamam = 1'b1;
`endif
        if (tamam) begin
          tablo_d[tq_q][6'(ZIGZAG[k_q])] = deger;
          if (k_q == 6'd63) begin
            gecerli_d[tq_q] = 1'b1;
            durum_d         = BASLIK;
          end else begin
            k_d = k_q + 6'd1;
          end
        end
        // A segment ending before the 64th value leaves the table invalid.
        if (dqt_son_i && !(tamam && k_q == 6'd63)) begin
          hata_d  = 1'b1;
          durum_d = BASLIK;
        end
      end
      ATLA: if (kabul && dqt_son_i) durum_d = BASLIK;
      default: durum_d = BASLIK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BASLIK;
      k_q       <= 6'd0;
      tq_q      <= '0;
      gecerli_q <= '0;
      hata_q    <= 1'b0;
      s_q       <= 3'd0;
      aktif_q   <= 1'b0;
      tablo_q   <= '{default: '0};
`ifdef NICEM_16BIT_EN
      pq_q      <= 1'b0;
      faz_q     <= 1'b0;
      ust_q     <= 8'd0;
`endif
    end else begin
      durum_q   <= durum_d;
      k_q       <= k_d;
      tq_q      <= tq_d;
      gecerli_q <= gecerli_d;
      hata_q    <= hata_d;
      s_q       <= s_d;
      aktif_q   <= aktif_d;
      tablo_q   <= tablo_d;
`ifdef NICEM_16BIT_EN
      pq_q      <= pq_d;
      faz_q     <= faz_d;
      ust_q     <= ust_d;
`endif
    end
  end
endmodule

// File: tb/tb_nicem_tablo_denetleyici.sv
// Bench for nicem_tablo_denetleyici: table loads, lookups, component sequence, hold-off and error paths.
module tb_nicem_tablo_denetleyici;
`ifdef NICEM_16BIT_EN
  localparam int DQ = 16;
`else
  localparam int DQ = 8;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [7:0]    dqt_veri_i = 8'd0;
  logic          dqt_gecerli_i = 1'b0;
  logic          dqt_son_i = 1'b0;
  logic          dqt_hazir_o;
  logic [1:0]    cfg_mcu_yapi_i = 2'd0;
  logic          cfg_y_tablo_i = 1'b0;
  logic          cfg_c_tablo_i = 1'b1;
  logic          mcu_sifirla_i = 1'b0;
  logic [5:0]    dq_index_i = 6'd0;
  logic          dq_istek_i = 1'b0;
  logic          blok_son_i = 1'b0;
  logic [DQ-1:0] dq_katsayi_o;
  logic          dq_gecerli_o;
  logic [1:0]    bilesen_o;
  logic          hata_o;
  logic [1:0]    durum_o;

  nicem_tablo_denetleyici dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .dqt_veri_i(dqt_veri_i), .dqt_gecerli_i(dqt_gecerli_i), .dqt_son_i(dqt_son_i),
    .dqt_hazir_o(dqt_hazir_o),
    .cfg_mcu_yapi_i(cfg_mcu_yapi_i), .cfg_y_tablo_i(cfg_y_tablo_i), .cfg_c_tablo_i(cfg_c_tablo_i),
    .mcu_sifirla_i(mcu_sifirla_i), .dq_index_i(dq_index_i), .dq_istek_i(dq_istek_i),
    .blok_son_i(blok_son_i), .dq_katsayi_o(dq_katsayi_o), .dq_gecerli_o(dq_gecerli_o),
    .bilesen_o(bilesen_o), .hata_o(hata_o), .durum_o(durum_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  int            test_sayisi = 0;
  int            hata_sayisi = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   mdl [2][64];
  logic          mdl_gec [2];
  int            zz [64];
  int            mdl_s = 0;
  int            bil_seq [7] = '{0, 0, 0, 0, 1, 2, 0};

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    test_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic zigzag_kur();
    int i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[i] = r * 8 + (s - r); i++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[i] = r * 8 + (s - r); i++; end
      end
    end
  endtask

  function automatic int bek_bilesen();
    case (cfg_mcu_yapi_i)
      2'd1:    return mdl_s;
      2'd2:    return (mdl_s < 4) ? 0 : ((mdl_s == 4) ? 1 : 2);
      default: return 0;
    endcase
  endfunction

  function automatic int bek_sel();
    return (bek_bilesen() == 0) ? int'(cfg_y_tablo_i) : int'(cfg_c_tablo_i);
  endfunction

  task automatic saat();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sifirla();
    #2 rstn_i = 1'b0;
    #1;
    kontrol("rst_hazir", dqt_hazir_o, 1);
    kontrol("rst_gecerli", dq_gecerli_o, 0);
    kontrol("rst_katsayi", dq_katsayi_o, 0);
    kontrol("rst_bilesen", bilesen_o, 0);
    kontrol("rst_hata", hata_o, 0);
    for (int t = 0; t < 2; t++) begin
      mdl_gec[t] = 1'b0;
      for (int j = 0; j < 64; j++) mdl[t][j] = 16'd0;
    end
    mdl_s = 0;
    saat();
    rstn_i = 1'b1;
    saat();
  endtask

  // Driver tasks
  task automatic bayt_gonder(input logic [7:0] b, input logic son);
    bit alindi = 0;
    dqt_gecerli_i = 1'b1;
    dqt_veri_i    = b;
    dqt_son_i     = son;
    for (int i = 0; i < 20 && !alindi; i++) begin
      #1;
      if (dqt_hazir_o) alindi = 1;
      saat();
    end
    if (!alindi) kontrol("hazir_sure", 0, 1);
    dqt_gecerli_i = 1'b0;
    dqt_son_i     = 1'b0;
  endtask

  // mod 0: values k+1; otherwise every value equals sabit
  task automatic tablo_yukle(input int t, input int mod, input logic [7:0] sabit);
    logic [7:0] v;
    bayt_gonder(8'(t), 1'b0);
    mdl_gec[t] = 1'b0;
    for (int k = 0; k < 64; k++) begin
      v = (mod == 0) ? 8'(k + 1) : sabit;
      bayt_gonder(v, k == 63);
      mdl[t][zz[k]] = {8'd0, v};
    end
    mdl_gec[t] = 1'b1;
  endtask

  task automatic bak(input int idx);
    int s = bek_sel();
    exp_q.push_back(mdl[s][idx]);
    dq_index_i = 6'(idx);
    #1;
    kontrol("dq_gecerli", dq_gecerli_o, mdl_gec[s]);
    kontrol("katsayi", dq_katsayi_o, exp_q.pop_front());
  endtask

  task automatic blok_bitir();
    int lim = (cfg_mcu_yapi_i == 2'd1) ? 3 : ((cfg_mcu_yapi_i == 2'd2) ? 6 : 1);
    blok_son_i = 1'b1;
    saat();
    blok_son_i = 1'b0;
    mdl_s = (mdl_s + 1) % lim;
  endtask

  task automatic blok_baslat();
    dq_istek_i = 1'b1;
    saat();
    dq_istek_i = 1'b0;
  endtask

  initial begin
    zigzag_kur();
    sifirla();

    // Natural-order ramp in zigzag order
    tablo_yukle(0, 0, 8'd0);
    bak(1); bak(8); bak(63); bak(0);
    for (int i = 0; i < 4; i++) bak($urandom_range(0, 63));

    // 4:2:0 component walk over two tables
    tablo_yukle(0, 1, 8'd16);
    tablo_yukle(1, 1, 8'd99);
    cfg_mcu_yapi_i = 2'd2;
    for (int i = 0; i < 7; i++) begin
      #1;
      kontrol("bilesen_420", bilesen_o, bil_seq[i]);
      kontrol("bilesen_model", bilesen_o, bek_bilesen());
      bak($urandom_range(0, 63));
      if (i < 6) blok_bitir();
    end
    cfg_mcu_yapi_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      kontrol("bilesen_444", bilesen_o, bek_bilesen());
      bak($urandom_range(0, 63));
      blok_bitir();
    end
    mcu_sifirla_i = 1'b1; saat(); mcu_sifirla_i = 1'b0; mdl_s = 0;

    // Hold-off of a rewrite to the table in use
    cfg_mcu_yapi_i = 2'd2;
    blok_baslat();
    dqt_gecerli_i = 1'b1; dqt_veri_i = 8'h01; #1;
    kontrol("hazir_diger", dqt_hazir_o, 1);
    dqt_veri_i = 8'h00; #1;
    kontrol("hazir_tut", dqt_hazir_o, 0);
    saat();
    kontrol("hazir_tut2", dqt_hazir_o, 0);
    blok_son_i = 1'b1; #1;
    kontrol("hazir_son", dqt_hazir_o, 0);
    saat();
    blok_son_i = 1'b0; mdl_s = 1;
    kontrol("hazir_sonra", dqt_hazir_o, 1);
    saat();
    dqt_gecerli_i = 1'b0;
    mdl_gec[0] = 1'b0;
    kontrol("gecerli_dustu", dq_gecerli_o, 0);
    for (int k = 0; k < 64; k++) begin
      bayt_gonder(8'd7, k == 63);
      mdl[0][zz[k]] = 16'd7;
    end
    mdl_gec[0] = 1'b1;
    bak(0); bak(37);
    // clear wins over set
    dq_istek_i = 1'b1; blok_son_i = 1'b1; saat();
    dq_istek_i = 1'b0; blok_son_i = 1'b0; mdl_s = 2;
    dqt_gecerli_i = 1'b1; dqt_veri_i = 8'h00; #1;
    kontrol("temizle_oncelik", dqt_hazir_o, 1);
    dqt_gecerli_i = 1'b0;
    mcu_sifirla_i = 1'b1; saat(); mcu_sifirla_i = 1'b0; mdl_s = 0;

    // Bad headers
    bayt_gonder(8'h12, 1'b0);
    kontrol("hata_tq2", hata_o, 1);
    kontrol("durum_atla", durum_o, 2);
    for (int i = 0; i < 10; i++) bayt_gonder(8'($urandom_range(0, 255)), i == 9);
    kontrol("durum_baslik", durum_o, 0);
    bak(0); bak(20); bak(63);
    bayt_gonder(8'h05, 1'b0);
    kontrol("hata_tq5", hata_o, 1);
    kontrol("durum_atla2", durum_o, 2);
    bayt_gonder(8'h00, 1'b1);
    kontrol("durum_geri", durum_o, 0);

    // Reset during a load, then a truncated segment
    bayt_gonder(8'h00, 1'b0);
    for (int i = 0; i < 10; i++) bayt_gonder(8'd3, 1'b0);
    sifirla();
    cfg_mcu_yapi_i = 2'd0; cfg_y_tablo_i = 1'b1;
    bak(0);
    bayt_gonder(8'h01, 1'b0);
    for (int k = 0; k < 30; k++) begin
      bayt_gonder(8'(50 + k), k == 29);
      mdl[1][zz[k]] = 16'(50 + k);
    end
    kontrol("hata_kisa", hata_o, 1);
    bak(zz[5]); bak(zz[40]);
    cfg_y_tablo_i = 1'b0;
    cfg_mcu_yapi_i = 2'd1;
    blok_bitir(); blok_bitir();
    #1 kontrol("bilesen_cr", bilesen_o, 2);
    blok_baslat();
    mcu_sifirla_i = 1'b1; blok_son_i = 1'b1; saat();
    mcu_sifirla_i = 1'b0; blok_son_i = 1'b0; mdl_s = 0;
    kontrol("sifirla_oncelik", bilesen_o, 0);
    dqt_gecerli_i = 1'b1; dqt_veri_i = 8'h00; #1;
    kontrol("sifirla_aktif", dqt_hazir_o, 1);
    dqt_gecerli_i = 1'b0;

    // Pq=1
    sifirla();
    cfg_mcu_yapi_i = 2'd0;
`ifdef NICEM_16BIT_EN
    bayt_gonder(8'h10, 1'b0);
    for (int k = 0; k < 64; k++) begin
      bayt_gonder(8'h01, 1'b0);
      bayt_gonder(8'h2C, k == 63);
      mdl[0][zz[k]] = 16'd300;
    end
    mdl_gec[0] = 1'b1;
    kontrol("hata_pq1", hata_o, 0);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(16'd300);
      dq_index_i = 6'(i);
      #1;
      kontrol("katsayi_300", dq_katsayi_o, exp_q.pop_front());
    end
    bak(5);
`else
    bayt_gonder(8'h10, 1'b0);
    kontrol("hata_pq1", hata_o, 1);
    kontrol("durum_pq1", durum_o, 2);
    bak(5);
`endif

    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL zaman_asimi: gozlenen=0 beklenen=1");
    $fatal(1);
  end
endmodule
